// File: rtl/pixel_fifo.sv
// Pixel FIFO: array storage, wrapping pointers, occupancy and push/pop arbitration.
// The head entry is held in a register, so a push is visible only one cycle later.
module pixel_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_ready_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       drop_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              full, empty, pop, accept;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop     = !empty && pop_ready_i;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign accept  = push_i && (!full || pop);
    assign drop_o  = push_i && full && !pop;
    assign data_o  = head_q;
    assign valid_o = !empty;
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(accept) - LVL_W'(pop);
        head_d   = '0;
        if (level_d != '0) begin
            // The entry being written this edge becomes head when it is the only one left.
            if (accept && (rd_ptr_d == wr_ptr_q)) begin
                head_d = push_data_i;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end
endmodule

// File: rtl/pixel_collector.sv
// Assembles LSB-first serial bits into grayscale pixels and queues them in a FIFO.
// Keeps a sticky overflow flag for completed pixels dropped while the FIFO is full.
module pixel_collector #(
    parameter int PIXEL_BITS = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_bit,
    input  logic                          output_bit,
    input  logic                          line_start,
    output logic [PIXEL_BITS-1:0]         pixel_data,
    output logic                          pixel_valid,
    input  logic                          pixel_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          clear_overflow
);
    localparam int CNT_W = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIXEL_BITS - 1);

    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [PIXEL_BITS-1:0] asm_q, asm_d;
    logic [PIXEL_BITS-1:0] merged;
    logic                  overflow_q, overflow_d;
    logic                  push, drop;

    // Assembly register with the incoming bit placed at the current position.
    for (genvar gi = 0; gi < PIXEL_BITS; gi++) begin : g_merge
        assign merged[gi] = (bit_cnt_q == CNT_W'(gi)) ? output_bit : asm_q[gi];
    end

    assign push = valid_bit && !line_start && (bit_cnt_q == LAST_CNT);

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        asm_d      = asm_q;
        if (line_start) begin
            bit_cnt_d = '0;
            asm_d     = '0;
        end else if (valid_bit) begin
            if (bit_cnt_q == LAST_CNT) begin
                bit_cnt_d = '0;
                asm_d     = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                asm_d     = merged;
            end
        end
        // A fresh drop beats a simultaneous clear.
        overflow_d = drop || (overflow_q && !clear_overflow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            asm_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            asm_q      <= asm_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    pixel_fifo #(
        .DATA_W (PIXEL_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (merged),
        .pop_ready_i (pixel_ready),
        .data_o      (pixel_data),
        .valid_o     (pixel_valid),
        .level_o     (level),
        .drop_o      (drop)
    );
endmodule

// File: tb/tb_pixel_collector.sv
// Directed bench for pixel_collector: a per-cycle vector table plus hand-written
// sequences for FIFO full, overflow and reset corner cases.
module tb_pixel_collector;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_bit = 1'b0;
    logic       output_bit = 1'b0;
    logic       line_start = 1'b0;
    logic [3:0] pixel_data;
    logic       pixel_valid;
    logic       pixel_ready = 1'b0;
    logic [3:0] level;
    logic       overflow;
    logic       clear_overflow = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pixel_collector #(
        .PIXEL_BITS (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_bit      (valid_bit),
        .output_bit     (output_bit),
        .line_start     (line_start),
        .pixel_data     (pixel_data),
        .pixel_valid    (pixel_valid),
        .pixel_ready    (pixel_ready),
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    typedef struct {
        string      name;
        logic       r, ls, vb, ob, rdy, clr;
        logic       exp_v;
        logic [3:0] exp_d;
        logic [3:0] exp_lvl;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic r, ls, vb, ob, rdy, clr,
                       input logic ev, input logic [3:0] ed, el, input logic eo);
        vec_t v;
        v.name = nm; v.r = r; v.ls = ls; v.vb = vb; v.ob = ob; v.rdy = rdy; v.clr = clr;
        v.exp_v = ev; v.exp_d = ed; v.exp_lvl = el; v.exp_ovf = eo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; line_start = 1'b0; valid_bit = 1'b0; output_bit = 1'b0;
        pixel_ready = 1'b0; clear_overflow = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Four back-to-back bits LSB first; optional pop and clear on the last bit.
    task automatic send_pixel(input logic [3:0] v, input logic pop_last, input logic clr_last);
        for (int b = 0; b < 4; b++) begin
            valid_bit      = 1'b1;
            output_bit     = v[b];
            pixel_ready    = pop_last && (b == 3);
            clear_overflow = clr_last && (b == 3);
            tick();
        end
        idle_inputs();
    endtask

    task automatic pop_expect(input string name, input logic [3:0] exp);
        check({name, "_valid"}, 32'(pixel_valid), 32'd1);
        check({name, "_data"}, 32'(pixel_data), 32'(exp));
        pixel_ready = 1'b1;
        tick();
        pixel_ready = 1'b0;
    endtask

    initial begin
        // name, rst, line_start, valid_bit, bit, ready, clr | valid, data, level, ovf
        add("reset",    1,0,0,0,0,0, 0,4'h0,0,0);
        add("idle",     0,0,0,0,0,0, 0,4'h0,0,0);
        // 1,0,1,1 -> 4'hD on the fifth cycle
        add("d_b0",     0,0,1,1,0,0, 0,4'h0,0,0);
        add("d_b1",     0,0,1,0,0,0, 0,4'h0,0,0);
        add("d_b2",     0,0,1,1,0,0, 0,4'h0,0,0);
        add("d_b3",     0,0,1,1,0,0, 1,4'hD,1,0);
        add("d_hold",   0,0,0,0,0,0, 1,4'hD,1,0);
        add("d_pop",    0,0,0,0,1,0, 0,4'h0,0,0);
        // partial pixel discarded by line_start (its own bit too), then 0,1,0,0 -> 2
        add("l_b0",     0,0,1,1,0,0, 0,4'h0,0,0);
        add("l_b1",     0,0,1,1,0,0, 0,4'h0,0,0);
        add("l_b2",     0,0,1,1,0,0, 0,4'h0,0,0);
        add("l_start",  0,1,1,1,0,0, 0,4'h0,0,0);
        add("l_n0",     0,0,1,0,0,0, 0,4'h0,0,0);
        add("l_n1",     0,0,1,1,0,0, 0,4'h0,0,0);
        add("l_n2",     0,0,1,0,0,0, 0,4'h0,0,0);
        add("l_n3",     0,0,1,0,0,0, 1,4'h2,1,0);
        add("l_pop",    0,0,0,0,1,0, 0,4'h0,0,0);
        // gapped bits 1,0,1,1 -> D
        add("g_b0",     0,0,1,1,0,0, 0,4'h0,0,0);
        add("g_i0",     0,0,0,1,0,0, 0,4'h0,0,0);
        add("g_b1",     0,0,1,0,0,0, 0,4'h0,0,0);
        add("g_i1",     0,0,0,1,0,0, 0,4'h0,0,0);
        add("g_i2",     0,0,0,0,0,0, 0,4'h0,0,0);
        add("g_b2",     0,0,1,1,0,0, 0,4'h0,0,0);
        add("g_i3",     0,0,0,0,0,0, 0,4'h0,0,0);
        add("g_i4",     0,0,0,0,0,0, 0,4'h0,0,0);
        add("g_i5",     0,0,0,0,0,0, 0,4'h0,0,0);
        add("g_b3",     0,0,1,1,0,0, 1,4'hD,1,0);
        // gapped bits 0,1,1,0 -> 6 while D stays held at the head
        add("h_b0",     0,0,1,0,0,0, 1,4'hD,1,0);
        add("h_b1",     0,0,1,1,0,0, 1,4'hD,1,0);
        add("h_i0",     0,0,0,0,0,0, 1,4'hD,1,0);
        add("h_i1",     0,0,0,1,0,0, 1,4'hD,1,0);
        add("h_b2",     0,0,1,1,0,0, 1,4'hD,1,0);
        add("h_i2",     0,0,0,0,0,0, 1,4'hD,1,0);
        add("h_b3",     0,0,1,0,0,0, 1,4'hD,2,0);
        add("h_pop1",   0,0,0,0,1,0, 1,4'h6,1,0);
        add("h_pop2",   0,0,0,0,1,0, 0,4'h0,0,0);

        idle_inputs();
        #2;
        foreach (vecs[i]) begin
            rst = vecs[i].r; line_start = vecs[i].ls; valid_bit = vecs[i].vb;
            output_bit = vecs[i].ob; pixel_ready = vecs[i].rdy; clear_overflow = vecs[i].clr;
            tick();
            check({vecs[i].name, "_valid"}, 32'(pixel_valid), 32'(vecs[i].exp_v));
            check({vecs[i].name, "_level"}, 32'(level), 32'(vecs[i].exp_lvl));
            check({vecs[i].name, "_ovf"}, 32'(overflow), 32'(vecs[i].exp_ovf));
            if (vecs[i].exp_v)
                check({vecs[i].name, "_data"}, 32'(pixel_data), 32'(vecs[i].exp_d));
        end
        idle_inputs();

        // Nine pixels into depth 8 with no consumer: ninth dropped, order kept.
        do_reset();
        for (int p = 0; p < 8; p++) send_pixel(4'(p + 1), 1'b0, 1'b0);
        check("fill8_level", 32'(level), 32'd8);
        check("fill8_ovf", 32'(overflow), 32'd0);
        send_pixel(4'h9, 1'b0, 1'b0);
        check("ovf9_level", 32'(level), 32'd8);
        check("ovf9_ovf", 32'(overflow), 32'd1);
        for (int p = 0; p < 8; p++) pop_expect($sformatf("drain9_%0d", p), 4'(p + 1));
        check("drain9_empty", 32'(pixel_valid), 32'd0);
        check("drain9_level", 32'(level), 32'd0);
        check("drain9_sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);

        // Clear and a new drop on the same edge: set wins.
        for (int p = 0; p < 8; p++) send_pixel(4'(p + 3), 1'b0, 1'b0);
        send_pixel(4'hF, 1'b0, 1'b1);
        check("setwins_ovf", 32'(overflow), 32'd1);
        check("setwins_level", 32'(level), 32'd8);

        // Full FIFO, last bit coincides with a pop: accepted, appears last.
        do_reset();
        check("rst_ovf", 32'(overflow), 32'd0);
        for (int p = 0; p < 8; p++) send_pixel(4'(p + 1), 1'b0, 1'b0);
        send_pixel(4'hE, 1'b1, 1'b0);
        check("fullpop_level", 32'(level), 32'd8);
        check("fullpop_ovf", 32'(overflow), 32'd0);
        for (int p = 0; p < 7; p++) pop_expect($sformatf("fullpop_%0d", p), 4'(p + 2));
        pop_expect("fullpop_last", 4'hE);
        check("fullpop_empty", 32'(level), 32'd0);

        // Reset mid-pixel with three queued; rst dominates other inputs.
        for (int p = 0; p < 3; p++) send_pixel(4'(p + 10), 1'b0, 1'b0);
        valid_bit = 1'b1; output_bit = 1'b1; tick();
        valid_bit = 1'b1; output_bit = 1'b1; tick();
        check("pre_rst_level", 32'(level), 32'd3);
        rst = 1'b1; valid_bit = 1'b1; output_bit = 1'b1; line_start = 1'b1; pixel_ready = 1'b1;
        tick();
        idle_inputs();
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_valid", 32'(pixel_valid), 32'd0);
        check("midrst_data", 32'(pixel_data), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        send_pixel(4'h5, 1'b0, 1'b0);
        check("postrst_level", 32'(level), 32'd1);
        pop_expect("postrst_pix", 4'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
